// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pixel clock-enable and registered, zero-skew outputs.
// Optional macro VGA_FRAME_COUNT_EN builds a 16-bit frame counter; otherwise frame_count is tied to 0.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CW         = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          display_on,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_start,
  output logic [15:0]   frame_count
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_BEG   = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = H_ACTIVE + H_FRONT + H_SYNC;
  localparam int unsigned VS_BEG   = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = V_ACTIVE + V_FRONT + V_SYNC;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_VBL  = CW'(V_ACTIVE);

  if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
    $fatal(1, "vga_timing_gen: sync width must be non-zero");
  end
  if (CW > 31 || ((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0) begin : g_bad_cw
    $fatal(1, "vga_timing_gen: CW too small for H_TOTAL-1/V_TOTAL-1");
  end

  logic          running_q;
  logic [CW-1:0] hpos_q, vpos_q;
  logic          hsync_q, vsync_q, display_q;
  logic          line_q, frame_q, vblank_q;

  logic [CW-1:0] h_d, v_d;
  logic [31:0]   h_w, v_w;
  logic          hsync_d, vsync_d, display_d;
  logic          line_d, frame_d, vblank_d;

  // Next raster position; the first enabled edge after reset presents (0,0) without advancing.
  always_comb begin
    h_d = hpos_q;
    v_d = vpos_q;
    if (!running_q) begin
      h_d = '0;
      v_d = '0;
    end else if (hpos_q == H_LAST) begin
      h_d = '0;
      v_d = (vpos_q == V_LAST) ? '0 : vpos_q + CW'(1);
    end else begin
      h_d = hpos_q + CW'(1);
    end
  end

  // Decode on the position about to be presented so all outputs share one pixel slot.
  always_comb begin
    h_w       = 32'(h_d);
    v_w       = 32'(v_d);
    display_d = (h_w < H_ACTIVE) && (v_w < V_ACTIVE);
    hsync_d   = ((h_w >= HS_BEG) && (h_w < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d   = ((v_w >= VS_BEG) && (v_w < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
    line_d    = (h_d == '0);
    frame_d   = line_d && (v_d == '0);
    vblank_d  = line_d && (v_d == V_VBL);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      running_q <= 1'b0;
      hpos_q    <= '0;
      vpos_q    <= '0;
      display_q <= 1'b0;
      hsync_q   <= ~H_SYNC_POL;
      vsync_q   <= ~V_SYNC_POL;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
      vblank_q  <= 1'b0;
    end else if (pix_ce) begin
      running_q <= 1'b1;
      hpos_q    <= h_d;
      vpos_q    <= v_d;
      display_q <= display_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
      vblank_q  <= vblank_d;
    end else begin
      // Strobes are single-clk pulses even when the enable is sparse.
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
      vblank_q  <= 1'b0;
    end
  end

  assign hpos         = hpos_q;
  assign vpos         = vpos_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign display_on   = display_q;
  assign line_start   = line_q;
  assign frame_start  = frame_q;
  assign vblank_start = vblank_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_cnt_q;

  // The start-up frame is frame 0; each later frame start counts up modulo 2^16.
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt_q <= '0;
    end else if (pix_ce && running_q && frame_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing, a short-line variant for
// vertical/frame behaviour, and a tiny active-high configuration for frame_count.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic rst_d = 1'b0, ce_d = 1'b0;
  logic hs_d, vs_d, de_d, ls_d, fs_d, vb_d;
  logic [9:0] hp_d, vp_d;
  logic [15:0] fc_d;

  // short-line instance: H=16/2/4/2 (24 total), default vertical timing
  logic rst_m = 1'b0, ce_m = 1'b0;
  logic hs_m, vs_m, de_m, ls_m, fs_m, vb_m;
  logic [9:0] hp_m, vp_m;
  logic [15:0] fc_m;

  // tiny instance: H=8/1/2/1, V=4/1/1/1, active-high syncs
  logic rst_s = 1'b0, ce_s = 1'b0;
  logic hs_s, vs_s, de_s, ls_s, fs_s, vb_s;
  logic [3:0] hp_s, vp_s;
  logic [15:0] fc_s;

  vga_timing_gen dut_d (
    .clk(clk), .reset(rst_d), .pix_ce(ce_d),
    .hsync(hs_d), .vsync(vs_d), .display_on(de_d), .hpos(hp_d), .vpos(vp_d),
    .line_start(ls_d), .frame_start(fs_d), .vblank_start(vb_d), .frame_count(fc_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2)
  ) dut_m (
    .clk(clk), .reset(rst_m), .pix_ce(ce_m),
    .hsync(hs_m), .vsync(vs_m), .display_on(de_m), .hpos(hp_m), .vpos(vp_m),
    .line_start(ls_m), .frame_start(fs_m), .vblank_start(vb_m), .frame_count(fc_m)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CW(4)
  ) dut_s (
    .clk(clk), .reset(rst_s), .pix_ce(ce_s),
    .hsync(hs_s), .vsync(vs_s), .display_on(de_s), .hpos(hp_s), .vpos(vp_s),
    .line_start(ls_s), .frame_start(fs_s), .vblank_start(vb_s), .frame_count(fc_s)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int first_a, last_a, cnt_a, err_a, err_b, gap, mark, wrap_h, wrap_v, vb_h, vb_v;
  int fc_at[2];
  int k;
  logic en, prev_ls, prev_fs, prev_vs;
  logic [9:0] prev_h, prev_v;

  initial begin
    // ---------------- default instance: reset and start-up
    rst_d = 1'b0; ce_d = 1'b1;
    repeat (3) tick();
    check("d_rst_hpos", int'(hp_d), 0);
    check("d_rst_vpos", int'(vp_d), 0);
    check("d_rst_de", int'(de_d), 0);
    check("d_rst_hs", int'(hs_d), 1);
    check("d_rst_vs", int'(vs_d), 1);
    check("d_rst_ls", int'(ls_d), 0);
    check("d_rst_fs", int'(fs_d), 0);
    check("d_rst_vb", int'(vb_d), 0);
    check("d_rst_fc", int'(fc_d), 0);
    rst_d = 1'b1;
    tick();
    check("d_start_hpos", int'(hp_d), 0);
    check("d_start_vpos", int'(vp_d), 0);
    check("d_start_de", int'(de_d), 1);
    check("d_start_ls", int'(ls_d), 1);
    check("d_start_fs", int'(fs_d), 1);
    check("d_start_hs", int'(hs_d), 1);
    tick();
    check("d_fs_width", int'(fs_d), 0);
    check("d_adv_hpos", int'(hp_d), 1);

    // one full line at full rate
    first_a = -1; last_a = -1; cnt_a = 0; err_a = 0; mark = -1; gap = -1;
    for (int i = 2; i <= 800; i++) begin
      tick();
      if (i < 800 && hp_d != 10'(i)) err_a++;
      if (!hs_d) begin
        if (first_a < 0) first_a = int'(hp_d);
        last_a = int'(hp_d);
        cnt_a++;
      end
      if (!de_d && mark < 0) mark = int'(hp_d);
      if (ls_d && gap < 0) gap = i;
    end
    check("d_hs_first", first_a, 656);
    check("d_hs_last", last_a, 751);
    check("d_hs_width", cnt_a, 96);
    check("d_de_fall", mark, 640);
    check("d_hpos_seq_err", err_a, 0);
    check("d_line_period", gap, 800);
    check("d_wrap_hpos", int'(hp_d), 0);
    check("d_wrap_vpos", int'(vp_d), 1);
    check("d_wrap_fs", int'(fs_d), 0);

    // reset with the enable low, then 1-in-4 enable
    ce_d = 1'b0; rst_d = 1'b0;
    tick();
    check("d_rst_noce_vpos", int'(vp_d), 0);
    check("d_rst_noce_de", int'(de_d), 0);
    rst_d = 1'b1;
    prev_h = hp_d; prev_ls = 1'b0; prev_fs = 1'b0;
    err_a = 0; err_b = 0; mark = -1; gap = -1;
    for (int c = 0; c < 7000; c++) begin
      ce_d = (c % 4 == 0);
      en = ce_d;
      tick();
      if (!en && hp_d != prev_h) err_a++;
      if ((ls_d && prev_ls) || (fs_d && prev_fs)) err_b++;
      if (!en && (ls_d || fs_d || vb_d)) err_b++;
      if (ls_d) begin
        if (mark < 0) mark = c;
        else if (gap < 0) gap = c - mark;
      end
      prev_h = hp_d; prev_ls = ls_d; prev_fs = fs_d;
    end
    check("d_ce4_hold_err", err_a, 0);
    check("d_ce4_strobe_err", err_b, 0);
    check("d_ce4_first_ls", mark, 0);
    check("d_ce4_line_period", gap, 3200);
    check("d_ce4_end_hpos", int'(hp_d), 149);
    check("d_ce4_end_vpos", int'(vp_d), 2);
    ce_d = 1'b0; rst_d = 1'b0;

    // ---------------- short-line instance: vertical timing and frame wrap
    ce_m = 1'b1; rst_m = 1'b0;
    tick();
    rst_m = 1'b1;
    tick();
    check("m_start_fs", int'(fs_m), 1);
    check("m_start_vpos", int'(vp_m), 0);
    first_a = -1; last_a = -1; cnt_a = 0; err_a = 0;
    vb_h = -1; vb_v = -1; wrap_h = -1; wrap_v = -1; gap = -1;
    prev_vs = 1'b1; prev_h = hp_m; prev_v = vp_m;
    for (int i = 1; i <= 12605; i++) begin
      tick();
      if (vs_m != prev_vs && hp_m != 10'd0) err_a++;
      if (!vs_m) begin
        if (first_a < 0) first_a = int'(vp_m);
        last_a = int'(vp_m);
        cnt_a++;
      end
      if (vb_m && vb_h < 0) begin
        vb_h = int'(hp_m); vb_v = int'(vp_m);
      end
      if (fs_m && gap < 0) begin
        gap = i; wrap_h = int'(prev_h); wrap_v = int'(prev_v);
      end
      prev_vs = vs_m; prev_h = hp_m; prev_v = vp_m;
    end
    check("m_vs_first", first_a, 490);
    check("m_vs_last", last_a, 491);
    check("m_vs_width", cnt_a, 48);
    check("m_vs_edge_err", err_a, 0);
    check("m_vb_hpos", vb_h, 0);
    check("m_vb_vpos", vb_v, 480);
    check("m_wrap_from_h", wrap_h, 23);
    check("m_wrap_from_v", wrap_v, 524);
    check("m_frame_period", gap, 12600);

    // mid-frame reset at (12,200)
    repeat (4807) tick();
    check("m_mid_hpos", int'(hp_m), 12);
    check("m_mid_vpos", int'(vp_m), 200);
    rst_m = 1'b0;
    tick();
    check("m_mrst_hpos", int'(hp_m), 0);
    check("m_mrst_vpos", int'(vp_m), 0);
    check("m_mrst_de", int'(de_m), 0);
    check("m_mrst_hs", int'(hs_m), 1);
    check("m_mrst_vs", int'(vs_m), 1);
    check("m_mrst_ls", int'(ls_m), 0);
    rst_m = 1'b1;
    tick();
    check("m_restart_hpos", int'(hp_m), 0);
    check("m_restart_vpos", int'(vp_m), 0);
    check("m_restart_fs", int'(fs_m), 1);
    check("m_restart_de", int'(de_m), 1);
    ce_m = 1'b0; rst_m = 1'b0;

    // ---------------- tiny instance: active-high syncs and frame_count
    ce_s = 1'b1; rst_s = 1'b0;
    tick();
    check("s_rst_hs", int'(hs_s), 0);
    check("s_rst_vs", int'(vs_s), 0);
    rst_s = 1'b1;
    tick();
    check("s_start_fs", int'(fs_s), 1);
    check("s_start_fc", int'(fc_s), 0);
    first_a = -1; last_a = -1; cnt_a = 0; mark = -1; last_a = -1;
    vb_h = -1; vb_v = -1; gap = -1; k = 0; fc_at[0] = -1; fc_at[1] = -1;
    for (int i = 1; i <= 168; i++) begin
      tick();
      if (hs_s) begin
        if (first_a < 0) first_a = int'(hp_s);
        last_a = int'(hp_s);
      end
      if (vs_s) begin
        if (vb_h < 0) vb_h = int'(vp_s);
        vb_v = int'(vp_s);
      end
      if (de_s) cnt_a++;
      if (fs_s) begin
        if (gap < 0) gap = i;
        if (k < 2) fc_at[k] = int'(fc_s);
        k++;
      end
    end
    check("s_hs_first", first_a, 9);
    check("s_hs_last", last_a, 10);
    check("s_vs_first", vb_h, 5);
    check("s_vs_last", vb_v, 5);
    check("s_de_count", cnt_a, 64);
    check("s_frame_period", gap, 84);
    check("s_frame_starts", k, 2);
`ifdef VGA_FRAME_COUNT_EN
    check("s_fc_frame1", fc_at[0], 1);
    check("s_fc_frame2", fc_at[1], 2);
    force dut_s.frame_cnt_q = 16'hFFFF;
    tick();
    release dut_s.frame_cnt_q;
    check("s_fc_forced", int'(fc_s), 65535);
    gap = -1;
    for (int i = 0; i < 100 && gap < 0; i++) begin
      tick();
      if (fs_s) gap = int'(fc_s);
    end
    check("s_fc_rollover", gap, 0);
`else
    check("s_fc_frame1", fc_at[0], 0);
    check("s_fc_frame2", fc_at[1], 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
